// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the CNN layer controllers.
// The maxpool1 read controller imports its state encoding and response tag from here.
package cnn_ctrl_pkg;

    localparam int NUM_OUT_DEFAULT        = 5408;
    localparam int ADDR_W_DEFAULT         = 13;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1048576;
    localparam int TO_W_DEFAULT           = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_READY = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // 0 = conv2 input loader, 1 = RISC-V debug/readback
    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    oob;
    } resp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with combinational grants.
// `last` remembers the most recent winner; on a tie the other requester wins.
module rr_arb2
    import cnn_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    req_id_t last;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last == 1'b1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Resetting to 1 makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last <= 1'b1;
        end else if (gnt[0]) begin
            last <= 1'b0;
        end else if (gnt[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/maxpool1_read_ctrl.sv
// Launches and supervises the first max-pool run, then shares its single
// result read port between the conv2 loader (r0) and the debug path (r1).
module maxpool1_read_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_OUT        = NUM_OUT_DEFAULT,
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TO_W           = TO_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic              clear,
    output logic              busy,
    output logic              pool_ready,
    output logic              error,
    output logic              pool_start,
    input  logic              pool_done,
    output logic [31:0]       pool_read_addr,
    input  logic [7:0]        pool_read_data,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [7:0]        r0_rdata,
    output logic [7:0]        r1_rdata,
    output state_t            dbg_state
);

    state_t            state, state_n;
    logic [TO_W-1:0]   to_cnt;
    logic              done_q;
    logic              done_edge;
    logic              timeout_hit;
    logic              leave_ready;

    assign done_edge   = pool_done & ~done_q;
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= pool_done;
            if (state == ST_START) begin
                to_cnt <= '0;
            end else if (state == ST_RUN) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // A done edge in the timeout cycle still counts as completion.
    always_comb begin
        state_n    = state;
        busy       = 1'b0;
        pool_ready = 1'b0;
        error      = 1'b0;
        pool_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_n = ST_START;
            end
            ST_START: begin
                busy       = 1'b1;
                pool_start = 1'b1;
                state_n    = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (done_edge) begin
                    state_n = ST_READY;
                end else if (timeout_hit) begin
                    state_n = ST_ERROR;
                end
            end
            ST_READY: begin
                pool_ready = 1'b1;
                if (clear) begin
                    state_n = ST_IDLE;
                end else if (go) begin
                    state_n = ST_START;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
                if (clear) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign leave_ready = (state == ST_READY) && (state_n != ST_READY);

    // Handshake: a requester holds req/addr until it sees gnt in the same
    // cycle; each granted request returns exactly one rvalid two cycles later
    // unless READY is left first.
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oob;
    logic [ADDR_W-1:0] addr_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({r1_req, r0_req}),
        .enable (state == ST_READY),
        .gnt    (gnt)
    );

    assign r0_gnt   = gnt[0];
    assign r1_gnt   = gnt[1];
    assign sel_addr = gnt[1] ? r1_addr : r0_addr;
    assign sel_oob  = ({{(32-ADDR_W){1'b0}}, sel_addr} >= 32'(NUM_OUT));

    // Out-of-range reads leave the pool address untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q <= '0;
        end else if ((gnt != 2'b00) && !sel_oob) begin
            addr_q <= sel_addr;
        end
    end

    assign pool_read_addr = {{(32-ADDR_W){1'b0}}, addr_q};

    resp_tag_t s1, s2;

    always_ff @(posedge clk) begin
        if (!resetn || leave_ready) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1.valid <= (gnt != 2'b00);
            s1.id    <= gnt[1];
            s1.oob   <= sel_oob;
            s2       <= s1;
        end
    end

    logic [7:0] resp_data;
    logic [7:0] r0_hold, r1_hold;

    assign resp_data = s2.oob ? 8'h00 : pool_read_data;
    assign r0_rvalid = s2.valid && (s2.id == 1'b0);
    assign r1_rvalid = s2.valid && (s2.id == 1'b1);
    assign r0_rdata  = r0_rvalid ? resp_data : r0_hold;
    assign r1_rdata  = r1_rvalid ? resp_data : r1_hold;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r0_hold <= 8'h00;
            r1_hold <= 8'h00;
        end else begin
            if (r0_rvalid) r0_hold <= resp_data;
            if (r1_rvalid) r1_hold <= resp_data;
        end
    end

endmodule

// File: tb/tb_maxpool1_read_ctrl.sv
// Directed bench for maxpool1_read_ctrl: launch, reads, arbitration, kill,
// reset and timeout (on a second instance with a short timeout).
module tb_maxpool1_read_ctrl;
    import cnn_ctrl_pkg::*;

    localparam int NUM_OUT = 5408;
    localparam int ADDR_W  = 13;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic go = 1'b0, clear = 1'b0, pool_done = 1'b0;
    logic r0_req = 1'b0, r1_req = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
    logic [7:0] pool_read_data = 8'h00;
    logic busy, pool_ready, error, pool_start;
    logic [31:0] pool_read_addr;
    logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    state_t dbg_state;

    logic t_go = 1'b0, t_clear = 1'b0, t_done = 1'b0;
    logic t_r0_req = 1'b0, t_r1_req = 1'b0;
    logic [ADDR_W-1:0] t_r0_addr = '0, t_r1_addr = '0;
    logic [7:0] t_pool_data = 8'h00;
    logic t_busy, t_ready, t_error, t_start;
    logic [31:0] t_rd_addr;
    logic t_g0, t_g1, t_v0, t_v1;
    logic [7:0] t_d0, t_d1;
    state_t t_state;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] pool_mem(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h6F;
    endfunction

    always @(posedge clk) pool_read_data <= pool_mem(pool_read_addr[ADDR_W-1:0]);

    maxpool1_read_ctrl dut (
        .clk(clk), .resetn(resetn), .go(go), .clear(clear),
        .busy(busy), .pool_ready(pool_ready), .error(error), .pool_start(pool_start),
        .pool_done(pool_done), .pool_read_addr(pool_read_addr), .pool_read_data(pool_read_data),
        .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .dbg_state(dbg_state)
    );

    maxpool1_read_ctrl #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut_to (
        .clk(clk), .resetn(resetn), .go(t_go), .clear(t_clear),
        .busy(t_busy), .pool_ready(t_ready), .error(t_error), .pool_start(t_start),
        .pool_done(t_done), .pool_read_addr(t_rd_addr), .pool_read_data(t_pool_data),
        .r0_req(t_r0_req), .r1_req(t_r1_req), .r0_addr(t_r0_addr), .r1_addr(t_r1_addr),
        .r0_gnt(t_g0), .r1_gnt(t_g1), .r0_rvalid(t_v0), .r1_rvalid(t_v1),
        .r0_rdata(t_d0), .r1_rdata(t_d1), .dbg_state(t_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp();
        logic [40:0] e;
        if (r0_rvalid || r1_rvalid) begin
            chk("one_rvalid", 32'(r0_rvalid & r1_rvalid), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_cycle", 32'(cyc), e[40:9]);
                chk("resp_id", 32'(r1_rvalid), 32'(e[8]));
                chk("resp_data", 32'(r1_rvalid ? r1_rdata : r0_rdata), 32'(e[7:0]));
            end
        end else if (exp_q.size() != 0 && exp_q[0][40:9] <= 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("missing_rvalid", 32'({r1_rvalid, r0_rvalid}), e[8] ? 32'd2 : 32'd1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_resp();
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(pool_ready), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_start"}, 32'(pool_start), 32'd0);
        chk({tag, "_gnt"}, 32'({r1_gnt, r0_gnt}), 32'd0);
        chk({tag, "_rvalid"}, 32'({r1_rvalid, r0_rvalid}), 32'd0);
        chk({tag, "_rd_addr"}, pool_read_addr, 32'd0);
        chk({tag, "_r0_rdata"}, 32'(r0_rdata), 32'd0);
        chk({tag, "_r1_rdata"}, 32'(r1_rdata), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [ADDR_W-1:0] q0, q1, last_addr;

        // Reset values on both instances
        repeat (3) step();
        chk_all_reset("rst");
        chk("t_rst_outs", 32'({t_busy, t_ready, t_error, t_start, t_g0, t_g1, t_v0, t_v1}), 32'd0);
        chk("t_rst_data", {t_rd_addr[15:0], t_d0, t_d1}, 32'd0);
        resetn = 1'b1;

        // Basic launch: go in cycle 10, done edge in cycle 110
        while (cyc < 10) step();
        go = 1'b1;
        step();
        go = 1'b0;
        chk("launch_start", 32'(pool_start), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        for (int k = 12; k <= 109; k++) begin
            step();
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_start", 32'(pool_start), 32'd0);
            chk("run_ready", 32'(pool_ready), 32'd0);
        end
        step();
        pool_done = 1'b1;
        chk("done_cycle_busy", 32'(busy), 32'd1);
        chk("done_cycle_ready", 32'(pool_ready), 32'd0);
        step();
        chk("ready_after_done", 32'(pool_ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        pool_done = 1'b0;

        // Single read from r0
        step();
        r0_req = 1'b1;
        r0_addr = 13'h015;
        #1;
        chk("single_gnt", 32'({r1_gnt, r0_gnt}), 32'd1);
        exp_q.push_back({32'(cyc + 2), 1'b0, 8'h7A});
        step();
        r0_req = 1'b0;
        chk("single_rd_addr", pool_read_addr, 32'h15);
        step();
        chk("single_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("single_r1_rvalid", 32'(r1_rvalid), 32'd0);
        step();
        chk("rdata_hold", 32'(r0_rdata), 32'h7A);
        chk("rvalid_one_cycle", 32'(r0_rvalid), 32'd0);

        // Out-of-range read from r1
        r1_req = 1'b1;
        r1_addr = 13'(NUM_OUT);
        #1;
        chk("oob_gnt", 32'({r1_gnt, r0_gnt}), 32'd2);
        exp_q.push_back({32'(cyc + 2), 1'b1, 8'h00});
        step();
        r1_req = 1'b0;
        chk("oob_rd_addr", pool_read_addr, 32'h15);
        step();
        chk("oob_r1_rvalid", 32'(r1_rvalid), 32'd1);
        step();

        // Contention: both held for six cycles, fresh address after each grant
        q0 = 13'($urandom_range(0, NUM_OUT - 1));
        q1 = 13'($urandom_range(0, NUM_OUT - 1));
        last_addr = '0;
        for (int i = 0; i < 6; i++) begin
            r0_req = 1'b1;
            r1_req = 1'b1;
            r0_addr = q0;
            r1_addr = q1;
            #1;
            if (i % 2 == 0) begin
                chk("cont_gnt_r0", 32'({r1_gnt, r0_gnt}), 32'd1);
                exp_q.push_back({32'(cyc + 2), 1'b0, pool_mem(q0)});
                last_addr = q0;
                q0 = 13'($urandom_range(0, NUM_OUT - 1));
            end else begin
                chk("cont_gnt_r1", 32'({r1_gnt, r0_gnt}), 32'd2);
                exp_q.push_back({32'(cyc + 2), 1'b1, pool_mem(q1)});
                last_addr = q1;
                q1 = 13'($urandom_range(0, NUM_OUT - 1));
            end
            step();
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        step();
        step();
        chk("cont_drained", 32'(exp_q.size()), 32'd0);
        chk("cont_rd_addr", pool_read_addr, 32'(last_addr));

        // Kill: clear one cycle after a grant drops the response
        r0_req = 1'b1;
        r0_addr = 13'h100;
        #1;
        chk("kill_gnt", 32'({r1_gnt, r0_gnt}), 32'd1);
        step();
        r0_req = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("kill_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        chk("kill_state", 32'(dbg_state), 32'(ST_IDLE));
        r0_req = 1'b1;
        #1;
        chk("idle_no_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
        step();
        r0_req = 1'b0;
        chk("kill_rvalid_late", 32'({r1_rvalid, r0_rvalid}), 32'd0);

        // Run, rerun from READY, then go+clear together (clear wins)
        go = 1'b1;
        step();
        go = 1'b0;
        chk("run2_start", 32'(pool_start), 32'd1);
        step();
        pool_done = 1'b1;
        step();
        pool_done = 1'b0;
        chk("run2_ready", 32'(pool_ready), 32'd1);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("rerun_start", 32'(pool_start), 32'd1);
        chk("rerun_busy", 32'(busy), 32'd1);
        step();
        go = 1'b1;
        clear = 1'b1;
        step();
        chk("run_ignores_cmds", 32'(dbg_state), 32'(ST_RUN));
        go = 1'b0;
        clear = 1'b0;
        pool_done = 1'b1;
        step();
        pool_done = 1'b0;
        chk("rerun_ready", 32'(pool_ready), 32'd1);
        go = 1'b1;
        clear = 1'b1;
        step();
        go = 1'b0;
        clear = 1'b0;
        chk("clear_wins_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("clear_wins_busy", 32'(busy), 32'd0);

        // Reset in the middle of RUN
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        step();
        chk_all_reset("mid_rst");
        resetn = 1'b1;
        step();

        // Timeout on the short-timeout instance
        t_go = 1'b1;
        step();
        t_go = 1'b0;
        chk("to_start", 32'(t_start), 32'd1);
        for (int k = 1; k <= 64; k++) begin
            step();
            chk("to_run_busy", 32'(t_busy), 32'd1);
            chk("to_run_error", 32'(t_error), 32'd0);
        end
        step();
        chk("to_error", 32'(t_error), 32'd1);
        chk("to_busy", 32'(t_busy), 32'd0);
        t_go = 1'b1;
        step();
        t_go = 1'b0;
        chk("to_go_ignored", 32'({t_error, t_start, t_busy}), 32'd4);
        t_clear = 1'b1;
        step();
        t_clear = 1'b0;
        chk("to_clear_error", 32'(t_error), 32'd0);
        chk("to_clear_state", 32'(t_state), 32'(ST_IDLE));
        chk("to_quiet", 32'({t_g0, t_g1, t_v0, t_v1, t_ready}), 32'd0);
        chk("to_read_side", {t_rd_addr[15:0], t_d0, t_d1}, 32'd0);

        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
